// File: rtl/shiftreg_pkg.sv
// rtl/shiftreg_pkg.sv - shared state encoding for the 74HC595 chain driver
package shiftreg_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_BIT_LO = 2'd1,
    ST_BIT_HI = 2'd2,
    ST_LATCH  = 2'd3
  } state_e;

endpackage

// File: rtl/shiftreg_phase_tick.sv
// rtl/shiftreg_phase_tick.sv - phase timer, ticks on the last cycle of each CLK_DIV-long phase
module shiftreg_phase_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_Restart,
  output logic o_Tick
);

  localparam int            PW   = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign o_Tick = (cnt_q == LAST);

  // Count 0..CLK_DIV-1 and wrap, so consecutive phases chain without a restart.
  always_comb begin
    cnt_d = cnt_q;
    if (i_Restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Phase counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shiftreg_chain.sv
// rtl/shiftreg_chain.sv - serial driver for a 74HC595 chain (optional /OE control: SHIFTREG_OE_EN)
module shiftreg_chain
  import shiftreg_pkg::*;
#(
  parameter int CHAIN_LEN = 2,
  parameter int CLK_DIV   = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [8*CHAIN_LEN-1:0] i_Data,
  input  logic                   i_Valid,
  output logic                   o_Ready,
  output logic                   o_Busy,
  output logic                   o_RCLK,
  output logic                   o_SRCLK,
  output logic                   o_SER
`ifdef SHIFTREG_OE_EN
  ,
  input  logic                   i_Blank,
  output logic                   o_OE_n
`endif
);

  localparam int            W        = 8 * CHAIN_LEN;
  localparam int            BW       = $clog2(W);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [W-1:0]   buf_q, buf_d;
  logic           buf_full_q, buf_full_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic           ready_q, busy_q, rclk_q, srclk_q, ser_q;
  logic           ser_d;
  logic           xfer;
  logic           tick;

  shiftreg_phase_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_Restart (state_q == ST_IDLE),
    .o_Tick    (tick)
  );

  assign xfer = i_Valid && ready_q;

  // Frame sequencing, hold-buffer bookkeeping and bit shifting.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    bit_cnt_d  = bit_cnt_q;

    // A transfer while a frame is in flight parks the word in the buffer.
    if (xfer && (state_q != ST_IDLE)) begin
      buf_d      = i_Data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          shift_d   = i_Data;
          bit_cnt_d = '0;
          state_d   = ST_BIT_LO;
        end
      end
      ST_BIT_LO: begin
        if (tick) state_d = ST_BIT_HI;
      end
      ST_BIT_HI: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_LATCH;
          end else begin
            state_d   = ST_BIT_LO;
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
          end
        end
      end
      ST_LATCH: begin
        if (tick) begin
          if (buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            bit_cnt_d  = '0;
            state_d    = ST_BIT_LO;
          end else if (xfer) begin
            // A word arriving on the final latch cycle goes straight to the shifter.
            shift_d    = i_Data;
            buf_full_d = 1'b0;
            bit_cnt_d  = '0;
            state_d    = ST_BIT_LO;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ser_d = 1'b0;
    if (state_d != ST_IDLE) begin
      ser_d = (LSB_FIRST != 0) ? shift_d[0] : shift_d[W-1];
    end
  end

  // State, data path and pin registers; pins are decoded from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      bit_cnt_q  <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      rclk_q     <= 1'b0;
      srclk_q    <= 1'b0;
      ser_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      bit_cnt_q  <= bit_cnt_d;
      ready_q    <= !buf_full_d;
      busy_q     <= (state_d != ST_IDLE);
      rclk_q     <= (state_d == ST_LATCH);
      srclk_q    <= (state_d == ST_BIT_HI);
      ser_q      <= ser_d;
    end
  end

  assign o_Ready = ready_q;
  assign o_Busy  = busy_q;
  assign o_RCLK  = rclk_q;
  assign o_SRCLK = srclk_q;
  assign o_SER   = ser_q;

`ifdef SHIFTREG_OE_EN
  logic oe_armed_q, oe_n_q;
  logic latch_done;

  assign latch_done = (state_q == ST_LATCH) && tick;

  // Keep the chain dark until a real frame has been latched, then follow blanking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      oe_armed_q <= 1'b0;
      oe_n_q     <= 1'b1;
    end else begin
      oe_armed_q <= oe_armed_q | latch_done;
      oe_n_q     <= (oe_armed_q | latch_done) ? i_Blank : 1'b1;
    end
  end

  assign o_OE_n = oe_n_q;
`endif

endmodule

// File: tb/tb_shiftreg_chain.sv
// tb/tb_shiftreg_chain.sv - scoreboard bench: two chain drivers checked against a model 595 chain
module tb_shiftreg_chain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_data;
  logic [7:0]  b_data;
  logic        a_valid, b_valid;
  logic        a_ready, a_busy, a_rclk, a_srclk, a_ser;
  logic        b_ready, b_busy, b_rclk, b_srclk, b_ser;
`ifdef SHIFTREG_OE_EN
  logic        blank;
  logic        a_oe_n, b_oe_n;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  // Monitor state per DUT (0: 16-bit MSB-first div 2, 1: 8-bit LSB-first div 1)
  logic [15:0] sr[2];
  int bits[2], hi[2], rw[2], start[2], nlatch[2], nb2b[2];
  logic [1:0] p_busy, p_rclk, p_srclk, p_ser;
  int mw, mcd;
  logic [15:0] got;

  wire [1:0] busy_v  = {b_busy, a_busy};
  wire [1:0] rclk_v  = {b_rclk, a_rclk};
  wire [1:0] srclk_v = {b_srclk, a_srclk};
  wire [1:0] ser_v   = {b_ser, a_ser};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shiftreg_chain #(.CHAIN_LEN(2), .CLK_DIV(2), .LSB_FIRST(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_Data(a_data), .i_Valid(a_valid),
    .o_Ready(a_ready), .o_Busy(a_busy), .o_RCLK(a_rclk), .o_SRCLK(a_srclk), .o_SER(a_ser)
`ifdef SHIFTREG_OE_EN
    , .i_Blank(blank), .o_OE_n(a_oe_n)
`endif
  );

  shiftreg_chain #(.CHAIN_LEN(1), .CLK_DIV(1), .LSB_FIRST(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_Data(b_data), .i_Valid(b_valid),
    .o_Ready(b_ready), .o_Busy(b_busy), .o_RCLK(b_rclk), .o_SRCLK(b_srclk), .o_SER(b_ser)
`ifdef SHIFTREG_OE_EN
    , .i_Blank(blank), .o_OE_n(b_oe_n)
`endif
  );

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %0h required %0h (cycle %0d)", k, name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Physical chain model: the bit shifted first travels to the far end (bit W-1),
  // so an MSB-first frame shows the word itself and an LSB-first frame shows it mirrored.
  task automatic send(input int k, input logic [15:0] w);
    int t = 0;
    if (k == 0) begin a_data = w; a_valid = 1'b1; end
    else begin b_data = w[7:0]; b_valid = 1'b1; end
    while ((((k == 0) ? a_ready : b_ready) == 1'b0) && (t < 1000)) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", k, (t < 1000), 1);
    if (t < 1000) begin
      if (k == 0) exp_a.push_back(w);
      else exp_b.push_back({8'h00, bitrev8(w[7:0])});
    end
    @(negedge clk);
    if (k == 0) a_valid = 1'b0;
    else b_valid = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (((k == 0) ? (a_busy || exp_a.size() != 0) : (b_busy || exp_b.size() != 0)) && (t < 5000));
    chk("idle_timeout", k, (t < 5000), 1);
  endtask

  // Monitor: rebuilds each frame on the model chain and checks its timing against the expected word.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        sr[k] = '0; bits[k] = 0; hi[k] = 0; rw[k] = 0; start[k] = cyc;
      end
      p_busy = '0; p_rclk = '0; p_srclk = '0; p_ser = '0;
      exp_a.delete();
      exp_b.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        mw  = (k == 0) ? 16 : 8;
        mcd = (k == 0) ? 2 : 1;
        if (busy_v[k] && (!p_busy[k] || (p_rclk[k] && !rclk_v[k]))) begin
          if (p_busy[k]) nb2b[k]++;
          start[k] = cyc;
          bits[k]  = 0;
        end
        if (srclk_v[k] && !p_srclk[k]) begin
          sr[k]   = 16'((({16'h0, sr[k]} << 1) | 32'(ser_v[k])) & ((32'd1 << mw) - 1));
          bits[k] = bits[k] + 1;
          hi[k]   = 1;
        end else if (srclk_v[k]) begin
          hi[k] = hi[k] + 1;
          chk("ser_hold", k, ser_v[k], p_ser[k]);
        end
        if (!srclk_v[k] && p_srclk[k]) chk("srclk_high_len", k, hi[k], mcd);
        if (rclk_v[k] && !p_rclk[k]) begin
          chk("cycles_to_rclk", k, cyc - start[k], 2 * mw * mcd);
          chk("bits_per_frame", k, bits[k], mw);
          rw[k] = 1;
        end else if (rclk_v[k]) begin
          rw[k] = rw[k] + 1;
        end
        if (!rclk_v[k] && p_rclk[k]) begin
          chk("rclk_width", k, rw[k], mcd);
          nlatch[k]++;
          chk("expected_pending", k, ((k == 0) ? exp_a.size() : exp_b.size()) > 0, 1);
          if (k == 0 && exp_a.size() > 0) begin
            got = exp_a.pop_front();
            chk("latched_word", k, sr[k], got);
          end else if (k == 1 && exp_b.size() > 0) begin
            got = exp_b.pop_front();
            chk("latched_word", k, sr[k], got);
          end
        end
        if (!busy_v[k] && p_busy[k]) chk("busy_fall_after_latch", k, p_rclk[k], 1);
      end
      p_busy = busy_v; p_rclk = rclk_v; p_srclk = srclk_v; p_ser = ser_v;
    end
  end

  initial begin
    int l0, b0, gap;
    for (int k = 0; k < 2; k++) begin nlatch[k] = 0; nb2b[k] = 0; end
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
`ifdef SHIFTREG_OE_EN
    blank = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_ready", 0, a_ready, 1);
    chk("reset_busy",  0, a_busy, 0);
    chk("reset_rclk",  0, a_rclk, 0);
    chk("reset_srclk", 0, a_srclk, 0);
    chk("reset_ser",   0, a_ser, 0);
    chk("reset_ready", 1, b_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
`ifdef SHIFTREG_OE_EN
    chk("oe_before_latch", 0, a_oe_n, 1);
`endif

    // Single MSB-first word on the 16-bit chain
    send(0, 16'hA5C3);
    wait_idle(0);
`ifdef SHIFTREG_OE_EN
    chk("oe_after_latch", 0, a_oe_n, 0);
`endif

    // Back-to-back with the second word parked in the hold buffer
    l0 = nlatch[0];
    b0 = nb2b[0];
    send(0, 16'h1234);
    send(0, 16'h5678);
    chk("ready_low_while_buffered", 0, a_ready, 0);
    wait_idle(0);
    chk("b2b_latch_count", 0, nlatch[0] - l0, 2);
    chk("b2b_no_idle_gap", 0, nb2b[0] - b0, 1);

    // LSB-first single bit and all-ones on the 8-bit, divide-by-1 chain
    send(1, 16'h0001);
    wait_idle(1);
    send(1, 16'h00FF);
    wait_idle(1);

    // Randomised traffic on both chains with gaps from none to long
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 90);
          repeat (gap) @(negedge clk);
          send(0, 16'($urandom));
        end
      end
      begin
        for (int i = 0; i < 24; i++) begin
          gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
          repeat (gap) @(negedge clk);
          send(1, 16'($urandom));
        end
      end
    join
    wait_idle(0);
    wait_idle(1);

`ifdef SHIFTREG_OE_EN
    blank = 1'b1;
    @(negedge clk);
    chk("oe_blank", 0, a_oe_n, 1);
    blank = 1'b0;
    @(negedge clk);
    chk("oe_unblank", 0, a_oe_n, 0);
`endif

    // Reset in the middle of a frame aborts it without a latch pulse
    send(0, 16'($urandom));
    begin
      int t = 0;
      while (bits[0] < 7 && t < 500) begin @(negedge clk); t++; end
      chk("reach_bit7_timeout", 0, (t < 500), 1);
    end
    l0 = nlatch[0];
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",  0, a_busy, 0);
    chk("abort_rclk",  0, a_rclk, 0);
    chk("abort_srclk", 0, a_srclk, 0);
    chk("abort_ser",   0, a_ser, 0);
    chk("abort_ready", 0, a_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_latch", 0, nlatch[0] - l0, 0);
    chk("abort_idle_busy", 0, a_busy, 0);
    chk("abort_ready_after", 0, a_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
